// File: rtl/mem_pkg.sv
// Shared definitions for the load/store controller: funct3 encodings, FSM
// states and the request legality check.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_e;

    // Unsigned variants exist only for loads; H needs even and W word-aligned addresses.
    function automatic logic access_err(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = addr_lo[0];
            F3_W:    err = |addr_lo;
            F3_BU:   err = we;
            F3_HU:   err = we | addr_lo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and data-memory bus of the load/store controller.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [3:0]        mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store replication with byte enables, and load
// lane selection with sign or zero extension.
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_v = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{byte_v[7] & (funct3_i == F3_B)}}, byte_v};
            end
            F3_H, F3_HU: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{half_v[15] & (funct3_i == F3_H)}}, half_v};
            end
            F3_W:    be_o = 4'b1111;
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the MEM stage and a word-addressed data memory
// with a fixed read latency; lane steering is delegated to lsu_align.
module lsu_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int MEM_LATENCY = 1
) (
    input logic           clk,
    input logic           rst_n,
    lsu_mem_ctrl_if.slave bus
);
    localparam int CNT_W = 4;

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              idle;
    logic [2:0]        align_funct3;
    logic [1:0]        align_addr_lo;
    logic [3:0]        store_be;
    logic [31:0]       store_data;
    logic [31:0]       load_data;

    assign idle = (state_q == IDLE);
    // The aligner steers the incoming store while idle and extracts the latched load later.
    assign align_funct3  = idle ? bus.req_funct3    : funct3_q;
    assign align_addr_lo = idle ? bus.req_addr[1:0] : addr_lo_q;

    lsu_align u_align (
        .funct3_i  (align_funct3),
        .addr_lo_i (align_addr_lo),
        .wdata_i   (bus.req_wdata),
        .rdata_i   (bus.mem_rdata),
        .be_o      (store_be),
        .wdata_o   (store_data),
        .rdata_o   (load_data)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        cnt_d       = cnt_q;
        mem_we_d    = 4'b0000;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d      = bus.req_we;
                    funct3_d  = bus.req_funct3;
                    addr_lo_d = bus.req_addr[1:0];
                    cnt_d     = '0;
                    if (access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d    = ACCESS;
                        mem_addr_d = bus.req_addr[ADDR_W-1:2];
                        if (bus.req_we) begin
                            mem_we_d    = store_be;
                            mem_wdata_d = store_data;
                        end
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d     = RESP;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end else if (cnt_q == CNT_W'(MEM_LATENCY)) begin
                    state_d     = RESP;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_data;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            cnt_q       <= '0;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = idle;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench: three controllers (read latency 1, 3, 4) receive the same
// requests; a scoreboard checks data, error flag and response cycle of each.
module tb_lsu_mem_ctrl;
    import mem_pkg::*;

    localparam int ADDR_W = 12;
    localparam int N = 3;
    localparam int LAT [N] = '{1, 3, 4};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        store;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int acc_cyc = -100;
    always @(posedge clk) cyc <= cyc + 1;

    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;

    logic [N-1:0]      ready_a, rsp_valid_a, rsp_err_a;
    logic [31:0]       rsp_rdata_a [N];
    logic [3:0]        mem_we_a [N];
    logic [ADDR_W-3:0] mem_addr_a [N];
    logic [31:0]       mem_wdata_a [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        lsu_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
        logic [31:0] mem [1 << (ADDR_W - 2)];

        assign bus.req_valid  = req_valid;
        assign bus.req_we     = req_we;
        assign bus.req_funct3 = req_funct3;
        assign bus.req_addr   = req_addr;
        assign bus.req_wdata  = req_wdata;
        // Read data is only meaningful in the one cycle the latency promises.
        assign bus.mem_rdata  = (cyc == acc_cyc + 1 + LAT[g]) ? mem[bus.mem_addr] : 32'hDEAD_BEEF;

        always @(posedge clk)
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];

        assign ready_a[g]     = bus.req_ready;
        assign rsp_valid_a[g] = bus.rsp_valid;
        assign rsp_err_a[g]   = bus.rsp_err;
        assign rsp_rdata_a[g] = bus.rsp_rdata;
        assign mem_we_a[g]    = bus.mem_we;
        assign mem_addr_a[g]  = bus.mem_addr;
        assign mem_wdata_a[g] = bus.mem_wdata;

        lsu_mem_ctrl #(.ADDR_W(ADDR_W), .MEM_LATENCY(LAT[g])) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    exp_t         exp_q [$];
    logic [N-1:0] done = '0;
    int           we_cnt [N];
    logic [3:0]   we_seen [N];
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input exp_t e, input int lat);
        if (e.err) return 1;
        if (e.store) return 2;
        return lat + 2;
    endfunction

    // Called once per cycle at the falling edge.
    task automatic sample_cycle();
        exp_t e;
        if (!rst_n) return;
        for (int i = 0; i < N; i++) begin
            if (mem_we_a[i] != 4'b0000) begin
                we_cnt[i]++;
                we_seen[i] = mem_we_a[i];
            end
            if (rsp_valid_a[i]) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("unexpected_rsp[%0d]", i), 32'(rsp_valid_a[i]), 32'd0);
                end else begin
                    e = exp_q[0];
                    check($sformatf("rdata[%0d]", i), rsp_rdata_a[i], e.rdata);
                    check($sformatf("err[%0d]", i), 32'(rsp_err_a[i]), 32'(e.err));
                    check($sformatf("rsp_cycle[%0d]", i), 32'(cyc - e.acc), 32'(exp_lat(e, LAT[i])));
                    done[i] = 1'b1;
                end
            end
        end
        if (done == '1) begin
            void'(exp_q.pop_front());
            done = '0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_ready[%0d]", tag, i), 32'(ready_a[i]), 32'd1);
            check($sformatf("%s_rsp_valid[%0d]", tag, i), 32'(rsp_valid_a[i]), 32'd0);
            check($sformatf("%s_rsp_err[%0d]", tag, i), 32'(rsp_err_a[i]), 32'd0);
            check($sformatf("%s_rsp_rdata[%0d]", tag, i), rsp_rdata_a[i], 32'd0);
            check($sformatf("%s_mem_we[%0d]", tag, i), 32'(mem_we_a[i]), 32'd0);
            check($sformatf("%s_mem_addr[%0d]", tag, i), 32'(mem_addr_a[i]), 32'd0);
            check($sformatf("%s_mem_wdata[%0d]", tag, i), mem_wdata_a[i], 32'd0);
        end
    endtask

    // Handshake in cycle 0; returns just after the accepting edge (start of cycle 1).
    task automatic issue(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input bit expect_rsp);
        exp_t e;
        int   k = 0;
        @(posedge clk); #1;
        while (ready_a != '1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (ready_a != '1) check("ready_timeout", 32'(ready_a), 32'((1 << N) - 1));
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clk);
        acc_cyc = cyc;
        for (int i = 0; i < N; i++) we_cnt[i] = 0;
        if (expect_rsp) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.store = we;
            e.acc   = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input logic [3:0] exp_we);
        int k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge clk);
            sample_cycle();
            k++;
        end
        if (exp_q.size() != 0) begin
            check("rsp_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            done = '0;
        end
        for (int i = 0; i < N; i++) begin
            check($sformatf("we_cycles[%0d]", i), 32'(we_cnt[i]), (exp_we != 4'b0000) ? 32'd1 : 32'd0);
            if (exp_we != 4'b0000) check($sformatf("we_value[%0d]", i), 32'(we_seen[i]), 32'(exp_we));
        end
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input logic [3:0] exp_we);
        issue(we, f3, addr, wdata, exp_rdata, exp_err, 1'b1);
        drain(exp_we);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            we_cnt[i]  = 0;
            we_seen[i] = 4'b0000;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Byte store to the top lane.
        issue(1'b1, F3_B, 12'h013, 32'h0000_00A5, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        sample_cycle();
        for (int i = 0; i < N; i++) begin
            check($sformatf("sb_mem_addr[%0d]", i), 32'(mem_addr_a[i]), 32'h004);
            check($sformatf("sb_mem_we[%0d]", i), 32'(mem_we_a[i]), 32'b1000);
            check($sformatf("sb_mem_wdata[%0d]", i), mem_wdata_a[i], 32'hA5A5_A5A5);
        end
        drain(4'b1000);

        // Word 4 = 0x12F03456: byte/halfword extraction and extension.
        run(1'b1, F3_W,  12'h010, 32'h12F0_3456, 32'h0,          1'b0, 4'b1111);
        run(1'b0, F3_B,  12'h012, 32'h0,         32'hFFFF_FFF0,  1'b0, 4'b0000);
        run(1'b0, F3_BU, 12'h012, 32'h0,         32'h0000_00F0,  1'b0, 4'b0000);
        run(1'b0, F3_W,  12'h010, 32'h0,         32'h12F0_3456,  1'b0, 4'b0000);
        run(1'b0, F3_H,  12'h010, 32'h0,         32'h0000_3456,  1'b0, 4'b0000);
        run(1'b0, F3_HU, 12'h012, 32'h0,         32'h0000_12F0,  1'b0, 4'b0000);
        run(1'b0, F3_B,  12'h010, 32'h0,         32'h0000_0056,  1'b0, 4'b0000);
        run(1'b0, F3_B,  12'h011, 32'h0,         32'h0000_0034,  1'b0, 4'b0000);

        // Word 0 = 0x80017FFF; LHU also checks req_ready stays low on the latency-3 unit.
        run(1'b1, F3_W, 12'h000, 32'h8001_7FFF, 32'h0, 1'b0, 4'b1111);
        issue(1'b0, F3_HU, 12'h002, 32'h0, 32'h0000_8001, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            sample_cycle();
            check($sformatf("lhu_ready_c%0d", k), 32'(ready_a[1]), 32'd0);
        end
        drain(4'b0000);
        run(1'b0, F3_H, 12'h002, 32'h0, 32'hFFFF_8001, 1'b0, 4'b0000);
        run(1'b0, F3_H, 12'h000, 32'h0, 32'h0000_7FFF, 1'b0, 4'b0000);
        run(1'b0, F3_B, 12'h001, 32'h0, 32'h0000_007F, 1'b0, 4'b0000);
        run(1'b0, F3_B, 12'h000, 32'h0, 32'hFFFF_FFFF, 1'b0, 4'b0000);

        // Misaligned and illegal requests.
        run(1'b1, F3_W,   12'h006, 32'h1234_5678, 32'h0, 1'b1, 4'b0000);
        run(1'b0, 3'b011, 12'h000, 32'h0,         32'h0, 1'b1, 4'b0000);
        run(1'b1, F3_H,   12'h001, 32'h0000_1234, 32'h0, 1'b1, 4'b0000);
        run(1'b1, F3_BU,  12'h000, 32'h0000_0012, 32'h0, 1'b1, 4'b0000);
        run(1'b0, F3_W,   12'h002, 32'h0,         32'h0, 1'b1, 4'b0000);
        run(1'b0, F3_HU,  12'h003, 32'h0,         32'h0, 1'b1, 4'b0000);
        run(1'b0, 3'b110, 12'h000, 32'h0,         32'h0, 1'b1, 4'b0000);

        // Reset pulse in cycle 2 of a load aborts it without a response.
        issue(1'b0, F3_W, 12'h010, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        sample_cycle();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            sample_cycle();
        end
        for (int i = 0; i < N; i++)
            check($sformatf("post_reset_ready[%0d]", i), 32'(ready_a[i]), 32'd1);
        run(1'b1, F3_W, 12'h000, 32'h1357_2468, 32'h0, 1'b0, 4'b1111);

        // Back-to-back halfword store and reload, then mixed sub-word updates.
        run(1'b1, F3_H,  12'h002, 32'hFFFF_9ABC, 32'h0,         1'b0, 4'b1100);
        run(1'b0, F3_H,  12'h002, 32'h0,         32'hFFFF_9ABC, 1'b0, 4'b0000);
        run(1'b0, F3_W,  12'h000, 32'h0,         32'h9ABC_2468, 1'b0, 4'b0000);
        run(1'b1, F3_H,  12'h000, 32'h0000_1111, 32'h0,         1'b0, 4'b0011);
        run(1'b0, F3_HU, 12'h000, 32'h0,         32'h0000_1111, 1'b0, 4'b0000);
        run(1'b1, F3_B,  12'h000, 32'h0000_0080, 32'h0,         1'b0, 4'b0001);
        run(1'b0, F3_B,  12'h000, 32'h0,         32'hFFFF_FF80, 1'b0, 4'b0000);
        run(1'b0, F3_W,  12'h000, 32'h0,         32'h9ABC_1180, 1'b0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
